axi4_slave_ram: RTL and testbench



---
 rtl/axi4_slave_ram.sv | 247 ++++++++++++++++++++++++
 tb/tb_axi4_slave_ram.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_ram.sv
// AXI4 memory-mapped slave backed by a word-addressed on-chip RAM.
// Independent write and read engines, one outstanding burst each, INCR only.
module axi4_slave_ram #(
   parameter int                    ID_WIDTH   = 14,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    MEM_AW     = 12,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ID_WIDTH-1:0]     s_axi_awid,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [7:0]              s_axi_awlen,
   input  logic [2:0]              s_axi_awsize,
   input  logic [1:0]              s_axi_awburst,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wlast,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [ID_WIDTH-1:0]     s_axi_bid,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ID_WIDTH-1:0]     s_axi_arid,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [7:0]              s_axi_arlen,
   input  logic [2:0]              s_axi_arsize,
   input  logic [1:0]              s_axi_arburst,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [ID_WIDTH-1:0]     s_axi_rid,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rlast,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready
);

   localparam int                    STRB_W     = DATA_WIDTH / 8;
   localparam int                    SIZE_LOG   = $clog2(STRB_W);
   localparam logic [2:0]            AXI_SIZE   = 3'(SIZE_LOG);
   localparam logic [ADDR_WIDTH-1:0] ADDR_INC   = ADDR_WIDTH'(STRB_W);
   localparam logic [1:0]            BURST_INCR = 2'b01;
   localparam logic [1:0]            RESP_OKAY  = 2'b00;
   localparam logic [1:0]            RESP_SLV   = 2'b10;
   localparam logic [1:0]            RESP_DEC   = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   logic [DATA_WIDTH-1:0] r_mem [2**MEM_AW];

   // Word index relative to BASE_ADDR; addresses below the base wrap to huge indices.
   function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] addr);
      return (addr - BASE_ADDR) >> SIZE_LOG;
   endfunction

   // ---------------- write engine ----------------
   w_state_t              r_w_state;
   logic                  r_awready, r_wready, r_bvalid;
   logic [1:0]            r_bresp;
   logic [ID_WIDTH-1:0]   r_bid;
   logic [ADDR_WIDTH-1:0] r_w_addr;
   logic [7:0]            r_w_len;
   logic [8:0]            r_w_cnt;
   logic                  r_w_berr, r_w_slverr, r_w_decerr;

   logic [ADDR_WIDTH-1:0] w_w_word;
   logic                  w_w_in_range, w_w_hs, w_w_live, w_w_we, w_w_dec, w_w_proto;

   assign w_w_word     = word_of(r_w_addr);
   assign w_w_in_range = (w_w_word[ADDR_WIDTH-1:MEM_AW] == '0);
   assign w_w_hs       = r_wready & s_axi_wvalid;
   assign w_w_live     = (r_w_cnt <= {1'b0, r_w_len});
   assign w_w_we       = w_w_hs & w_w_live & ~r_w_berr & w_w_in_range;
   assign w_w_dec      = w_w_hs & w_w_live & ~r_w_berr & ~w_w_in_range;
   assign w_w_proto    = w_w_hs & s_axi_wlast & (r_w_cnt != {1'b0, r_w_len});

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w_state  <= W_IDLE;
         r_awready  <= 1'b1;
         r_wready   <= 1'b0;
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
         r_bid      <= '0;
         r_w_addr   <= '0;
         r_w_len    <= '0;
         r_w_cnt    <= '0;
         r_w_berr   <= 1'b0;
         r_w_slverr <= 1'b0;
         r_w_decerr <= 1'b0;
      end else begin
         case (r_w_state)
            W_IDLE: begin
               if (s_axi_awvalid) begin
                  r_bid      <= s_axi_awid;
                  r_w_addr   <= s_axi_awaddr;
                  r_w_len    <= s_axi_awlen;
                  r_w_cnt    <= '0;
                  r_w_berr   <= (s_axi_awburst != BURST_INCR) | (s_axi_awsize != AXI_SIZE);
                  r_w_slverr <= 1'b0;
                  r_w_decerr <= 1'b0;
                  r_awready  <= 1'b0;
                  r_wready   <= 1'b1;
                  r_w_state  <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_w_hs) begin
                  // Counter parks at len+1 so surplus beats are recognised and dropped.
                  if (w_w_live) begin
                     r_w_cnt  <= r_w_cnt + 9'd1;
                     r_w_addr <= r_w_addr + ADDR_INC;
                  end
                  if (w_w_dec)   r_w_decerr <= 1'b1;
                  if (w_w_proto) r_w_slverr <= 1'b1;
                  if (s_axi_wlast) begin
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                     if (r_w_berr | r_w_slverr | w_w_proto) r_bresp <= RESP_SLV;
                     else if (r_w_decerr | w_w_dec)         r_bresp <= RESP_DEC;
                     else                                   r_bresp <= RESP_OKAY;
                     r_w_state <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_w_state <= W_IDLE;
               end
            end
            default: r_w_state <= W_IDLE;
         endcase
      end
   end

   // NOTE: RAM contents carry no reset; only control state is reset.
   always_ff @(posedge clk) begin
      if (w_w_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (s_axi_wstrb[b]) r_mem[w_w_word[MEM_AW-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
         end
      end
   end

   // ---------------- read engine ----------------
   r_state_t              r_r_state;
   logic                  r_arready, r_rvalid, r_rlast;
   logic [1:0]            r_rresp;
   logic [ID_WIDTH-1:0]   r_rid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [ADDR_WIDTH-1:0] r_r_addr;
   logic [7:0]            r_r_len, r_r_cnt;
   logic                  r_r_berr;

   logic                  w_ar_berr, w_r_berr, w_r_in_range;
   logic [ADDR_WIDTH-1:0] w_r_addr, w_r_word;
   logic [DATA_WIDTH-1:0] w_r_data;
   logic [1:0]            w_r_resp;

   // Address of the beat being loaded: the AR address at start, else the next beat.
   assign w_ar_berr    = (s_axi_arburst != BURST_INCR) | (s_axi_arsize != AXI_SIZE);
   assign w_r_addr     = (r_r_state == R_IDLE) ? s_axi_araddr : r_r_addr + ADDR_INC;
   assign w_r_berr     = (r_r_state == R_IDLE) ? w_ar_berr : r_r_berr;
   assign w_r_word     = word_of(w_r_addr);
   assign w_r_in_range = (w_r_word[ADDR_WIDTH-1:MEM_AW] == '0);

   always_comb begin
      w_r_data = '0;
      w_r_resp = RESP_OKAY;
      if (w_r_berr)           w_r_resp = RESP_SLV;
      else if (!w_r_in_range) w_r_resp = RESP_DEC;
      else                    w_r_data = r_mem[w_r_word[MEM_AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_r_state <= R_IDLE;
         r_arready <= 1'b1;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rresp   <= RESP_OKAY;
         r_rid     <= '0;
         r_rdata   <= '0;
         r_r_addr  <= '0;
         r_r_len   <= '0;
         r_r_cnt   <= '0;
         r_r_berr  <= 1'b0;
      end else begin
         case (r_r_state)
            R_IDLE: begin
               if (s_axi_arvalid) begin
                  r_rid     <= s_axi_arid;
                  r_r_addr  <= s_axi_araddr;
                  r_r_len   <= s_axi_arlen;
                  r_r_cnt   <= '0;
                  r_r_berr  <= w_ar_berr;
                  r_arready <= 1'b0;
                  r_rvalid  <= 1'b1;
                  r_rdata   <= w_r_data;
                  r_rresp   <= w_r_resp;
                  r_rlast   <= (s_axi_arlen == 8'd0);
                  r_r_state <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_axi_rready) begin
                  if (r_rlast) begin
                     r_rvalid  <= 1'b0;
                     r_rlast   <= 1'b0;
                     r_arready <= 1'b1;
                     r_r_state <= R_IDLE;
                  end else begin
                     r_r_addr <= w_r_addr;
                     r_r_cnt  <= r_r_cnt + 8'd1;
                     r_rdata  <= w_r_data;
                     r_rresp  <= w_r_resp;
                     r_rlast  <= (r_r_cnt + 8'd1 == r_r_len);
                  end
               end
            end
            default: r_r_state <= R_IDLE;
         endcase
      end
   end

   assign s_axi_awready = r_awready;
   assign s_axi_wready  = r_wready;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_bid     = r_bid;
   assign s_axi_arready = r_arready;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rlast   = r_rlast;
   assign s_axi_rresp   = r_rresp;
   assign s_axi_rid     = r_rid;
   assign s_axi_rdata   = r_rdata;

endmodule

// File: tb/tb_axi4_slave_ram.sv
// Directed self-checking bench for axi4_slave_ram (32-bit data, 4096-word RAM).
module tb_axi4_slave_ram;

   localparam int LIMIT = 600;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [13:0] s_axi_awid = '0, s_axi_arid = '0, s_axi_bid, s_axi_rid;
   logic [31:0] s_axi_awaddr = '0, s_axi_araddr = '0, s_axi_wdata = '0, s_axi_rdata;
   logic [7:0]  s_axi_awlen = '0, s_axi_arlen = '0;
   logic [2:0]  s_axi_awsize = 3'd2, s_axi_arsize = 3'd2;
   logic [1:0]  s_axi_awburst = 2'b01, s_axi_arburst = 2'b01, s_axi_bresp, s_axi_rresp;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_awvalid = 0, s_axi_wlast = 0, s_axi_wvalid = 0, s_axi_bready = 0;
   logic        s_axi_arvalid = 0, s_axi_rready = 0;
   logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready;
   logic        s_axi_rlast, s_axi_rvalid;

   always #5 clk = ~clk;

   axi4_slave_ram dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
      .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
      .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready), .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
      .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] wq_data[$];
   logic [3:0]  wq_strb[$];
   logic        b_lat;
   logic [1:0]  b_resp;
   logic [13:0] b_id;

   // Sends beats 0..last_beat from the queues; wlast marks last_beat.
   task automatic do_write(input logic [13:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int last_beat);
      int budget = 0;
      s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
      s_axi_awvalid = 1'b1;
      while (!s_axi_awready && budget < LIMIT) begin tick(); budget++; end
      check("aw_wait", 64'(budget < LIMIT), 1);
      tick();
      s_axi_awvalid = 1'b0;
      for (int i = 0; i <= last_beat; i++) begin
         s_axi_wdata = wq_data[i]; s_axi_wstrb = wq_strb[i];
         s_axi_wlast = (i == last_beat); s_axi_wvalid = 1'b1;
         budget = 0;
         while (!s_axi_wready && budget < LIMIT) begin tick(); budget++; end
         if (budget >= LIMIT) begin
            check("w_wait", 0, 1);
            break;
         end
         tick();
      end
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      b_lat = s_axi_bvalid;
      s_axi_bready = 1'b1;
      budget = 0;
      while (!s_axi_bvalid && budget < LIMIT) begin tick(); budget++; end
      check("b_wait", 64'(budget < LIMIT), 1);
      b_resp = s_axi_bresp; b_id = s_axi_bid;
      tick();
      s_axi_bready = 1'b0;
      wq_data.delete(); wq_strb.delete();
   endtask

   logic [31:0] rq_data[$];
   logic [1:0]  rq_resp[$];
   logic        rq_last[$];
   logic [13:0] r_id;
   logic        r_first;
   int          r_changes;

   // Collects every handshaken beat; counts output changes seen while stalled.
   task automatic do_read(input logic [13:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input bit toggle);
      int budget = 0;
      bit rr, stalled;
      logic [31:0] sd;
      logic [1:0]  sr;
      logic        sl;
      s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
      s_axi_arvalid = 1'b1;
      while (!s_axi_arready && budget < LIMIT) begin tick(); budget++; end
      check("ar_wait", 64'(budget < LIMIT), 1);
      tick();
      s_axi_arvalid = 1'b0;
      r_first = s_axi_rvalid;
      r_id = s_axi_rid;
      rq_data.delete(); rq_resp.delete(); rq_last.delete();
      r_changes = 0; stalled = 0; rr = !toggle; budget = 0;
      sd = '0; sr = '0; sl = 1'b0;
      while (rq_data.size() < int'(len) + 1 && budget < 4 * LIMIT) begin
         s_axi_rready = rr;
         if (s_axi_rvalid) begin
            if (stalled && (s_axi_rdata !== sd || s_axi_rresp !== sr || s_axi_rlast !== sl))
               r_changes++;
            if (rr) begin
               rq_data.push_back(s_axi_rdata);
               rq_resp.push_back(s_axi_rresp);
               rq_last.push_back(s_axi_rlast);
               stalled = 0;
            end else begin
               stalled = 1; sd = s_axi_rdata; sr = s_axi_rresp; sl = s_axi_rlast;
            end
         end
         tick();
         budget++;
         if (toggle) rr = !rr;
      end
      s_axi_rready = 1'b0;
      check("r_beats", rq_data.size(), int'(len) + 1);
      check("r_end_rvalid", s_axi_rvalid, 0);
      check("r_end_arready", s_axi_arready, 1);
   endtask

   initial begin
      int bad_data, n_last;
      #2 rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Reset values
      check("rst_awready", s_axi_awready, 1);
      check("rst_arready", s_axi_arready, 1);
      check("rst_wready", s_axi_wready, 0);
      check("rst_bvalid", s_axi_bvalid, 0);
      check("rst_rvalid", s_axi_rvalid, 0);
      check("rst_rlast", s_axi_rlast, 0);
      check("rst_bresp_bid", {s_axi_bresp, s_axi_bid}, 0);
      check("rst_rresp_rid_rdata", {s_axi_rresp, s_axi_rid, s_axi_rdata}, 0);

      // Single write then read
      wq_data.push_back(32'hDEAD_BEEF); wq_strb.push_back(4'hF);
      do_write(14'h005, 32'h10, 8'd0, 2'b01, 0);
      check("single_b_latency", b_lat, 1);
      check("single_bresp", b_resp, 2'b00);
      check("single_bid", b_id, 14'h005);
      do_read(14'h006, 32'h10, 8'd0, 2'b01, 0);
      check("single_r_first", r_first, 1);
      check("single_rid", r_id, 14'h006);
      check("single_rdata", rq_data[0], 32'hDEAD_BEEF);
      check("single_rlast", rq_last[0], 1);
      check("single_rresp", rq_resp[0], 2'b00);

      // 256-beat write (data = byte address), then stalled 256-beat read
      for (int k = 0; k < 256; k++) begin wq_data.push_back(32'(4 * k)); wq_strb.push_back(4'hF); end
      do_write(14'h011, 32'h0, 8'd255, 2'b01, 255);
      check("b256_bresp", b_resp, 2'b00);
      do_read(14'h012, 32'h0, 8'd255, 2'b01, 1);
      bad_data = 0; n_last = 0;
      for (int k = 0; k < rq_data.size(); k++) begin
         if (rq_data[k] !== 32'(4 * k) || rq_resp[k] !== 2'b00) bad_data++;
         if (rq_last[k]) n_last++;
      end
      check("r256_data_bad", bad_data, 0);
      check("r256_rlast_count", n_last, 1);
      check("r256_rlast_final", rq_last[rq_last.size() - 1], 1);
      check("r256_stall_stable", r_changes, 0);

      // Byte strobes
      wq_data.push_back(32'hFFFF_FFFF); wq_strb.push_back(4'hF);
      do_write(14'h020, 32'h40, 8'd0, 2'b01, 0);
      wq_data.push_back(32'h1122_3344); wq_strb.push_back(4'h5);
      do_write(14'h021, 32'h40, 8'd0, 2'b01, 0);
      do_read(14'h022, 32'h40, 8'd0, 2'b01, 0);
      check("strb_rdata", rq_data[0], 32'hFF22_FF44);

      // Out-of-range write from the last word: beat 0 lands, rest decode-error
      for (int k = 0; k < 4; k++) begin wq_data.push_back(32'hA0 + 32'(k)); wq_strb.push_back(4'hF); end
      do_write(14'h030, 32'h3FFC, 8'd3, 2'b01, 3);
      check("oor_bresp", b_resp, 2'b11);
      do_read(14'h031, 32'h0, 8'd0, 2'b01, 0);
      check("oor_word0", rq_data[0], 32'h0);
      do_read(14'h032, 32'h3FFC, 8'd0, 2'b01, 0);
      check("oor_last_word", rq_data[0], 32'hA0);
      do_read(14'h033, 32'h4000, 8'd0, 2'b01, 0);
      check("oor_rd_resp", rq_resp[0], 2'b11);
      check("oor_rd_data", rq_data[0], 32'h0);

      // Bad burst types
      do_read(14'h040, 32'h10, 8'd3, 2'b00, 0);
      for (int k = 0; k < 4; k++) begin
         check("fixed_rresp", rq_resp[k], 2'b10);
         check("fixed_rdata", rq_data[k], 32'h0);
      end
      check("fixed_rlast", rq_last[3], 1);
      wq_data.push_back(32'h1234_5678); wq_strb.push_back(4'hF);
      do_write(14'h041, 32'h80, 8'd0, 2'b10, 0);
      check("wrap_bresp", b_resp, 2'b10);
      do_read(14'h042, 32'h80, 8'd0, 2'b01, 0);
      check("wrap_no_write", rq_data[0], 32'h80);

      // Early wlast
      for (int k = 0; k < 2; k++) begin wq_data.push_back(32'hC0 + 32'(k)); wq_strb.push_back(4'hF); end
      do_write(14'h050, 32'h100, 8'd3, 2'b01, 1);
      check("early_wlast_bresp", b_resp, 2'b10);

      // Reset in the middle of a read burst
      s_axi_arid = 14'h060; s_axi_araddr = 32'h0; s_axi_arlen = 8'd15; s_axi_arburst = 2'b01;
      s_axi_arvalid = 1'b1;
      tick();
      s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b1;
      tick();
      s_axi_rready = 1'b0;
      check("mid_rvalid_before", s_axi_rvalid, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rvalid", s_axi_rvalid, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("mid_rst_arready", s_axi_arready, 1);
      check("mid_rst_rvalid_after", s_axi_rvalid, 0);

      // Concurrent write and read to disjoint ranges
      for (int k = 0; k < 16; k++) begin wq_data.push_back(32'h5000 + 32'(k)); wq_strb.push_back(4'hF); end
      fork
         do_write(14'h1A5, 32'h800, 8'd15, 2'b01, 15);
         do_read(14'h2B6, 32'h200, 8'd15, 2'b01, 0);
      join
      check("conc_bresp", b_resp, 2'b00);
      check("conc_bid", b_id, 14'h1A5);
      check("conc_rid", r_id, 14'h2B6);
      bad_data = 0;
      for (int k = 0; k < rq_data.size(); k++)
         if (rq_data[k] !== 32'h200 + 32'(4 * k) || rq_last[k] !== (k == 15)) bad_data++;
      check("conc_rdata_bad", bad_data, 0);
      do_read(14'h070, 32'h800, 8'd15, 2'b01, 0);
      bad_data = 0;
      for (int k = 0; k < rq_data.size(); k++)
         if (rq_data[k] !== 32'h5000 + 32'(k)) bad_data++;
      check("conc_wdata_bad", bad_data, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
